huffman_decoder: RTL and testbench

- Inverse of the Huffman encoding path. Takes the per-symbol code table (HC1..HC6, masks M1..M6) produced by the encoder side and a serial MSB-first codeword bitstream.
- Rebuilds the gray-level symbol stream as gray_data/gray_valid. This is the same format the symbol Counter consumes, so the decoder output can drive a Counter directly for round-trip checks.
- Raises a one-cycle done pulse after the configured number of symbols.

---
 rtl/huffman_decoder_pkg.sv | 26 ++
 rtl/huffman_match.sv | 27 ++
 rtl/huffman_decoder.sv | 103 ++++++++++
 tb/tb_huffman_decoder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/huffman_decoder_pkg.sv
// huffman_decoder_pkg: shared state encoding, code table type and symbol field layout
package huffman_decoder_pkg;

  localparam int SYM_NUM = 6;
  localparam int CODE_W = 8;
  localparam int SYM_W = 3;
  localparam int SYM_LSB = 0;
  localparam int SYM_MSB = SYM_LSB + SYM_W - 1;

  typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;

  // Entry 0 holds symbol 1, entry 5 holds symbol 6.
  typedef struct packed {
    logic [SYM_NUM-1:0][CODE_W-1:0] hc;
    logic [SYM_NUM-1:0][CODE_W-1:0] m;
  } code_table_t;

  // Symbol lives in gray_data[SYM_MSB:SYM_LSB]; the Counter reads the same field.
  function automatic logic [CODE_W-1:0] sym_to_gray(input logic [SYM_W-1:0] s);
    logic [CODE_W-1:0] g;
    g = '0;
    g[SYM_MSB:SYM_LSB] = s;
    return g;
  endfunction

endpackage

// File: rtl/huffman_match.sv
// huffman_match: six-way codeword comparator, lowest symbol index wins
module huffman_match
  import huffman_decoder_pkg::*;
(
  input  logic [CODE_W-1:0] sr_n,
  input  logic [3:0]        len_n,
  input  code_table_t       tbl,
  output logic              hit,
  output logic [SYM_W-1:0]  idx
);

  logic [CODE_W:0] full;

  assign full = (9'd1 << len_n) - 9'd1;

  // Scan from the highest index down so the lowest matching index is left standing.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = SYM_NUM - 1; i >= 0; i--)
      if (tbl.m[i] == full[CODE_W-1:0] && (sr_n & tbl.m[i]) == tbl.hc[i]) begin
        hit = 1'b1;
        idx = SYM_W'(i + 1);
      end
  end

endmodule

// File: rtl/huffman_decoder.sv
// huffman_decoder: serial MSB-first Huffman bitstream to gray-level symbol stream
module huffman_decoder
  import huffman_decoder_pkg::*;
#(
  parameter int NUM_SYM = 100,
  parameter int CNT_W = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        code_valid,
  input  logic [7:0]  HC1,
  input  logic [7:0]  HC2,
  input  logic [7:0]  HC3,
  input  logic [7:0]  HC4,
  input  logic [7:0]  HC5,
  input  logic [7:0]  HC6,
  input  logic [7:0]  M1,
  input  logic [7:0]  M2,
  input  logic [7:0]  M3,
  input  logic [7:0]  M4,
  input  logic [7:0]  M5,
  input  logic [7:0]  M6,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic [7:0]  gray_data,
  output logic        gray_valid,
  output logic        err,
  output logic        done
);

  state_t state, state_n;
  code_table_t tbl;
  logic [CODE_W-1:0] sr, sr_n;
  logic [3:0] len, len_n;
  logic [CNT_W-1:0] count;
  logic hit, last, take;
  logic [SYM_W-1:0] idx;

  assign sr_n = {sr[CODE_W-2:0], bit_in};
  assign len_n = len + 4'd1;
  assign take = state == DECODE && bit_valid && !code_valid;
  assign last = ({1'b0, count} + 1'b1) == (CNT_W+1)'(NUM_SYM);

  huffman_match u_match (
    .sr_n  (sr_n),
    .len_n (len_n),
    .tbl   (tbl),
    .hit   (hit),
    .idx   (idx)
  );

  // State register.
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;

  // A table load always (re)enters DECODE; the final symbol moves to DONE.
  always_comb begin
    state_n = state;
    if (code_valid) state_n = DECODE;
    else if (take && hit && last) state_n = DONE;
  end

  // Table, shift register, symbol counter and registered output pulses.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tbl <= '0;
      sr <= '0;
      len <= '0;
      count <= '0;
      gray_data <= '0;
      gray_valid <= 1'b0;
      err <= 1'b0;
      done <= 1'b0;
    end else begin
      gray_valid <= 1'b0;
      err <= 1'b0;
      done <= state == DONE && gray_valid;
      if (code_valid) begin
        tbl.hc <= {HC6, HC5, HC4, HC3, HC2, HC1};
        tbl.m <= {M6, M5, M4, M3, M2, M1};
        sr <= '0;
        len <= '0;
        count <= '0;
      end else if (take) begin
        if (hit) begin
          gray_data <= sym_to_gray(idx);
          gray_valid <= 1'b1;
          sr <= '0;
          len <= '0;
          count <= count + 1'b1;
        end else if (len_n == 4'd8) begin
          err <= 1'b1;
          sr <= '0;
          len <= '0;
        end else begin
          sr <= sr_n;
          len <= len_n;
        end
      end
    end

endmodule

// File: tb/tb_huffman_decoder.sv
// tb_huffman_decoder: directed table-driven checks of the Huffman decoder
module tb_huffman_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic code_valid = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic [7:0] hc [6];
  logic [7:0] m [6];
  logic [7:0] gray_data, gray_data4;
  logic gray_valid, err, done, gray_valid4, err4, done4;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_gd = 8'd0;

  typedef struct {
    logic cv;
    logic alt;
    logic bv;
    logic bi;
    int sym;
    logic er;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  huffman_decoder dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(hc[0]), .HC2(hc[1]), .HC3(hc[2]), .HC4(hc[3]), .HC5(hc[4]), .HC6(hc[5]),
    .M1(m[0]), .M2(m[1]), .M3(m[2]), .M4(m[3]), .M5(m[4]), .M6(m[5]),
    .bit_in(bit_in), .bit_valid(bit_valid),
    .gray_data(gray_data), .gray_valid(gray_valid), .err(err), .done(done)
  );

  huffman_decoder #(.NUM_SYM(4), .CNT_W(3)) dut4 (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(hc[0]), .HC2(hc[1]), .HC3(hc[2]), .HC4(hc[3]), .HC5(hc[4]), .HC6(hc[5]),
    .M1(m[0]), .M2(m[1]), .M3(m[2]), .M4(m[3]), .M5(m[4]), .M6(m[5]),
    .bit_in(bit_in), .bit_valid(bit_valid),
    .gray_data(gray_data4), .gray_valid(gray_valid4), .err(err4), .done(done4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_table(input logic alt);
    hc[0] = 8'h01; m[0] = 8'h01;
    hc[1] = 8'h00; m[1] = 8'h03;
    hc[2] = 8'h03; m[2] = 8'h07;
    hc[3] = 8'h04; m[3] = 8'h0F;
    hc[4] = 8'h0B; m[4] = 8'h1F;
    hc[5] = 8'h0A; m[5] = alt ? 8'h00 : 8'h1F;
  endtask

  task automatic step(input logic cv, input logic alt, input logic bv, input logic bi);
    set_table(alt);
    code_valid = cv;
    bit_valid = bv;
    bit_in = bi;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic cv, input logic alt, input logic bv,
                              input logic bi, input int sym, input logic er);
    vq.push_back('{cv: cv, alt: alt, bv: bv, bi: bi, sym: sym, er: er});
  endfunction

  function automatic void add_code(input logic [7:0] bits, input int len, input int sym,
                                   input logic er);
    for (int i = len - 1; i >= 0; i--)
      add(1'b0, 1'b0, 1'b1, bits[i], i == 0 ? sym : 0, i == 0 ? er : 1'b0);
  endfunction

  initial begin
    set_table(1'b0);
    // Back-to-back stream of all six codewords.
    add(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    add_code(8'b1, 1, 1, 1'b0);
    add_code(8'b00, 2, 2, 1'b0);
    add_code(8'b011, 3, 3, 1'b0);
    add_code(8'b0100, 4, 4, 1'b0);
    add_code(8'b01011, 5, 5, 1'b0);
    add_code(8'b01010, 5, 6, 1'b0);
    // "0100" with 3-cycle gaps between bits.
    add(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    for (int g = 0; g < 3; g++) add(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    for (int g = 0; g < 3; g++) add(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    for (int g = 0; g < 3; g++) add(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b0);
    // Symbol 6 removed: eight unmatched bits give err, then "1" still decodes.
    add(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    add_code(8'b01010, 5, 0, 1'b0);
    add_code(8'b000, 3, 0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    add_code(8'b1, 1, 1, 1'b0);
    // Table reload with a simultaneous bit aborts the partial "01".
    add(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    add_code(8'b01, 2, 0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    add_code(8'b00, 2, 2, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset gray_data", gray_data, 0);
    chk("reset gray_valid", gray_valid, 0);
    chk("reset err", err, 0);
    chk("reset done", done, 0);
    chk("reset done4", done4, 0);
    reset = 1'b0;

    // Idle state ignores bits before any table load.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("idle ignores bit", gray_valid, 0);

    foreach (vq[i]) begin
      step(vq[i].cv, vq[i].alt, vq[i].bv, vq[i].bi);
      if (vq[i].sym != 0) last_gd = 8'(vq[i].sym);
      chk($sformatf("vec%0d gray_valid", i), gray_valid, vq[i].sym != 0);
      chk($sformatf("vec%0d gray_data", i), gray_data, last_gd);
      chk($sformatf("vec%0d err", i), err, vq[i].er);
      chk($sformatf("vec%0d done", i), done, 0);
    end

    // NUM_SYM=4 instance: four "1" symbols, done one cycle later, then silence.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk($sformatf("n4 sym%0d gray_valid", k), gray_valid4, 1);
      chk($sformatf("n4 sym%0d gray_data", k), gray_data4, 1);
      chk($sformatf("n4 sym%0d done", k), done4, 0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("n4 done pulse", done4, 1);
    chk("n4 gray_valid after last", gray_valid4, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("n4 done one cycle", done4, 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk($sformatf("n4 extra%0d gray_valid", k), gray_valid4, 0);
      chk($sformatf("n4 extra%0d done", k), done4, 0);
    end

    // Reset in the middle of "011" after gray_data was left at 2.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pre-reset gray_data", gray_data, 2);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    bit_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async reset gray_data", gray_data, 0);
    chk("async reset gray_valid", gray_valid, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("in reset gray_valid", gray_valid, 0);
    chk("in reset err", err, 0);
    chk("in reset done", done, 0);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("no table after reset", gray_valid, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("reload gray_valid", gray_valid, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("post-reset gray_valid", gray_valid, 1);
    chk("post-reset gray_data", gray_data, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post-reset no stale", gray_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
